pc_target_table: RTL

//  Programmable branch-target / LDI-constant table: successor to the fixed PC lookup.

---
 rtl/pc_target_table.sv | 88 ++++++++
 1 files changed

// File: rtl/pc_target_table.sv
// pc_target_table: run-time loadable PC/constant lookup table with registered read,
// single-entry writes and a byte-serial little-endian stream loader.
module pc_target_table #(
    parameter int D         = 12,
    parameter int A         = 5,
    parameter int HALT_IDX  = 2**A - 1,
    parameter int HALT_TGT  = 511,
    parameter int LOCK_HALT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         rd_en,
    input  logic [A-1:0] addr,
    output logic [D-1:0] target,
    output logic         rd_valid,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    input  logic         ld_start,
    input  logic         ld_abort,
    input  logic         ld_valid,
    input  logic [7:0]   ld_byte,
    output logic         ld_ready,
    output logic         ld_done,
    output logic         busy
);
    localparam int DEPTH = 2**A;
    localparam int NB    = (D + 7) / 8;
    localparam int BW    = NB > 1 ? $clog2(NB) : 1;
    localparam int SW    = 8 * NB;

    typedef enum logic {IDLE, LOAD} state_t;

    state_t        state, state_nx;
    logic [D-1:0]  mem [DEPTH];
    logic [BW-1:0] bcnt;
    logic [A-1:0]  ecnt;
    logic [D-1:0]  asm_q, asm_nx;
    logic          accept, commit, last_ent, wr_ok, ld_ok;

    assign ld_ready = state == LOAD;
    assign busy     = state != IDLE;

    always_comb begin
        accept   = state == LOAD && ld_valid && !ld_abort;
        commit   = accept && bcnt == BW'(NB - 1);
        last_ent = ecnt == A'(DEPTH - 1);
        // bytes above bit D-1 fall off in the cast
        asm_nx   = asm_q | D'(SW'(ld_byte) << (8 * bcnt));
        wr_ok    = state == IDLE && wr_en && !(LOCK_HALT != 0 && wr_addr == A'(HALT_IDX));
        ld_ok    = commit && !(LOCK_HALT != 0 && ecnt == A'(HALT_IDX));
        state_nx = state == IDLE ? (ld_start ? LOAD : IDLE)
                 : (ld_abort || (commit && last_ent)) ? IDLE : LOAD;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= (i == HALT_IDX) ? D'(HALT_TGT) : '0;
            target   <= '0;
            rd_valid <= 1'b0;
            ld_done  <= 1'b0;
            bcnt     <= '0;
            ecnt     <= '0;
            asm_q    <= '0;
        end else begin
            rd_valid <= rd_en && state == IDLE;
            if (rd_en && state == IDLE) target <= mem[addr];
            ld_done <= commit && last_ent;
            if (wr_ok) mem[wr_addr] <= wr_data;
            if (ld_ok) mem[ecnt] <= asm_nx;
            // counters sit at zero whenever idle, so start and abort need no special case
            if (state == IDLE) begin
                bcnt  <= '0;
                ecnt  <= '0;
                asm_q <= '0;
            end else if (accept) begin
                bcnt  <= commit ? '0 : bcnt + 1'b1;
                ecnt  <= commit ? ecnt + 1'b1 : ecnt;
                asm_q <= commit ? '0 : asm_nx;
            end
        end
    end
endmodule
